// File: rtl/cpu_cfg_slave.sv
// cpu_cfg_slave: CPU bus slave (Intel/Motorola modes) owning the per-VPI cell config table,
// plus a one-cycle-latency core lookup port. Optional entry parity: CFG_PARITY_EN.
`default_nettype none

module cpu_cfg_slave #(
  parameter int          ENTRIES = 256,
  parameter logic [15:0] BASE    = 16'h0000,
  parameter int          CFG_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             BusMode,
  input  logic [23:0]      Addr,
  input  logic             Sel,
  input  logic [CFG_W-1:0] DataIn,
  output logic [CFG_W-1:0] DataOut,
  input  logic             Rd_DS,
  input  logic             Wr_RW,
  output logic             Rdy_Dtack,
  input  logic             lkup_en,
  input  logic [7:0]       lkup_addr,
  output logic [CFG_W-1:0] lkup_data,
  output logic             lkup_vld,
  output logic             err_addr
`ifdef CFG_PARITY_EN
  ,
  input  logic             perr_inj,
  output logic             lkup_perr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [23:0]      lat_addr;
  logic             lat_write;
  logic             lat_mode;
  logic [CFG_W-1:0] lat_data;
  logic [CFG_W-1:0] tbl [ENTRIES];

  logic start;
  logic hit;
  logic strobe_hi;
  logic commit;

  // Intel with both strobes low is not a legal cycle start.
  assign start     = !Sel && (BusMode ? (Rd_DS ^ Wr_RW) : !Rd_DS);
  assign hit       = (lat_addr[23:8] == BASE);
  assign strobe_hi = (lat_mode && lat_write) ? Wr_RW : Rd_DS;
  assign commit    = (state == S_ACCESS) && lat_write && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      Rdy_Dtack <= 1'b1;
      DataOut   <= '0;
      err_addr  <= 1'b0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_mode  <= 1'b0;
      lat_data  <= '0;
    end else begin
      err_addr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ACCESS;
            lat_addr  <= Addr;
            lat_write <= ~Wr_RW;
            lat_mode  <= BusMode;
            lat_data  <= DataIn;
            err_addr  <= (Addr[23:8] != BASE);
          end
        end
        S_ACCESS: begin
          state     <= S_ACK;
          Rdy_Dtack <= 1'b0;
          DataOut   <= (!lat_write && hit) ? tbl[lat_addr[7:0]] : '0;
        end
        S_ACK: begin
          if (strobe_hi && Sel) begin
            state     <= S_RELEASE;
            Rdy_Dtack <= 1'b1;
            DataOut   <= '0;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

`ifdef CFG_PARITY_EN
  logic par_tbl [ENTRIES];
`endif

  // Lookup samples the table before this edge's commit lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '0;
`ifdef CFG_PARITY_EN
        par_tbl[i] <= 1'b0;
`endif
      end
      lkup_vld  <= 1'b0;
      lkup_data <= '0;
`ifdef CFG_PARITY_EN
      lkup_perr <= 1'b0;
`endif
    end else begin
      if (commit) begin
        tbl[lat_addr[7:0]] <= lat_data;
`ifdef CFG_PARITY_EN
        par_tbl[lat_addr[7:0]] <= (^lat_data) ^ perr_inj;
`endif
      end
      lkup_vld  <= lkup_en;
      lkup_data <= lkup_en ? tbl[lkup_addr] : '0;
`ifdef CFG_PARITY_EN
      lkup_perr <= lkup_en && (par_tbl[lkup_addr] != (^tbl[lkup_addr]));
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_cfg_slave.sv
// tb_cpu_cfg_slave: vector table, hand sequences and randomized traffic vs. a table model.
`default_nettype none

module tb_cpu_cfg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        BusMode;
  logic [23:0] Addr;
  logic        Sel;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Rd_DS;
  logic        Wr_RW;
  logic        Rdy_Dtack;
  logic        lkup_en;
  logic [7:0]  lkup_addr;
  logic [15:0] lkup_data;
  logic        lkup_vld;
  logic        err_addr;
  logic        perr_inj;
  logic        lkup_perr;

  cpu_cfg_slave dut (
    .clk       (clk),
    .rst       (rst),
    .BusMode   (BusMode),
    .Addr      (Addr),
    .Sel       (Sel),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .Rd_DS     (Rd_DS),
    .Wr_RW     (Wr_RW),
    .Rdy_Dtack (Rdy_Dtack),
    .lkup_en   (lkup_en),
    .lkup_addr (lkup_addr),
    .lkup_data (lkup_data),
    .lkup_vld  (lkup_vld),
    .err_addr  (err_addr)
`ifdef CFG_PARITY_EN
    ,
    .perr_inj  (perr_inj),
    .lkup_perr (lkup_perr)
`endif
  );

`ifndef CFG_PARITY_EN
  assign lkup_perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] model [256];

  typedef struct {
    bit          mode;
    bit          wr;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic [15:0] rdata_hold;
    logic        rdy_hold;
    int          lat;
    int          errs;
    logic        rel_rdy;
    logic [15:0] rel_data;
  } res_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic release_bus();
    Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
  endtask

  task automatic cpu_access(input bit mode, input bit wr, input logic [23:0] a,
                            input logic [15:0] d, input bit inj, output res_t r);
    BusMode = mode; Addr = a; DataIn = d; Sel = 1'b0;
    Rd_DS = mode ? wr : 1'b0;
    Wr_RW = !wr;
    r.lat = 0; r.errs = 0;
    while (Rdy_Dtack !== 1'b0 && r.lat < 8) begin
      tick();
      r.lat++;
      if (err_addr === 1'b1) r.errs++;
      if (r.lat == 1) perr_inj = inj;
    end
    perr_inj = 1'b0;
    r.rdata = DataOut;
    tick();
    if (err_addr === 1'b1) r.errs++;
    r.rdy_hold = Rdy_Dtack;
    r.rdata_hold = DataOut;
    release_bus();
    tick();
    if (err_addr === 1'b1) r.errs++;
    r.rel_rdy = Rdy_Dtack;
    r.rel_data = DataOut;
    tick();
  endtask

  task automatic check_access(input string tag, input res_t r, input logic [15:0] exp, input bit exp_err);
    chk({tag, "_ack_lat"}, 32'(r.lat), 32'd2);
    chk({tag, "_rdata"}, 32'(r.rdata), 32'(exp));
    chk({tag, "_rdata_hold"}, 32'(r.rdata_hold), 32'(exp));
    chk({tag, "_rdy_hold"}, 32'(r.rdy_hold), 32'd0);
    chk({tag, "_err_cnt"}, 32'(r.errs), 32'(exp_err));
    chk({tag, "_rel_rdy"}, 32'(r.rel_rdy), 32'd1);
    chk({tag, "_rel_data"}, 32'(r.rel_data), 32'd0);
  endtask

  task automatic lookup(input logic [7:0] a, output logic [15:0] d, output logic v, output logic p);
    lkup_en = 1'b1; lkup_addr = a;
    tick();
    d = lkup_data; v = lkup_vld; p = lkup_perr;
    lkup_en = 1'b0;
    tick();
  endtask

  vec_t        vecs [8];
  res_t        r;
  logic [15:0] ld;
  logic        lv, lp;

  initial begin
    rst = 1'b1; BusMode = 1'b1; Addr = '0; Sel = 1'b1; DataIn = '0;
    Rd_DS = 1'b1; Wr_RW = 1'b1; lkup_en = 1'b0; lkup_addr = '0; perr_inj = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    vecs[0] = '{1'b1, 1'b1, 24'h000012, 16'hA5C3, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 24'h000012, 16'h0000, 16'hA5C3, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 24'h0000FF, 16'h1234, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 24'h0000FF, 16'h0000, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 24'h010005, 16'h0000, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 24'h010005, 16'hBEEF, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 24'h000005, 16'h0000, 16'h0000, 1'b0};

    tick(); tick();
    chk("rst_rdy", 32'(Rdy_Dtack), 32'd1);
    chk("rst_dout", 32'(DataOut), 32'd0);
    chk("rst_lkup_vld", 32'(lkup_vld), 32'd0);
    chk("rst_lkup_data", 32'(lkup_data), 32'd0);
    chk("rst_err", 32'(err_addr), 32'd0);
    chk("rst_lkup_perr", 32'(lkup_perr), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      cpu_access(vecs[i].mode, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, r);
      check_access($sformatf("vec%0d", i), r, vecs[i].exp, vecs[i].exp_err);
      if (vecs[i].wr && vecs[i].addr[23:8] == 16'h0000) model[vecs[i].addr[7:0]] = vecs[i].wdata;
    end

    // Write to entry 7 with a lookup landing on the commit edge.
    BusMode = 1'b1; Addr = 24'h000007; DataIn = 16'h00F0; Sel = 1'b0; Rd_DS = 1'b1; Wr_RW = 1'b0;
    tick();
    lkup_en = 1'b1; lkup_addr = 8'd7;
    tick();
    chk("coll_vld", 32'(lkup_vld), 32'd1);
    chk("coll_old_data", 32'(lkup_data), 32'd0);
    tick();
    chk("coll_new_data", 32'(lkup_data), 32'h00F0);
    lkup_en = 1'b0;
    tick();
    chk("lkup_idle_vld", 32'(lkup_vld), 32'd0);
    chk("lkup_idle_data", 32'(lkup_data), 32'd0);
    release_bus(); tick(); tick();
    model[7] = 16'h00F0;

    // Intel with both strobes low must not start a cycle.
    BusMode = 1'b1; Addr = 24'h010000; Sel = 1'b0; Rd_DS = 1'b0; Wr_RW = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bothlow_rdy", 32'(Rdy_Dtack), 32'd1);
      chk("bothlow_err", 32'(err_addr), 32'd0);
    end
    release_bus(); tick();

    // Reset during ACK of a read.
    BusMode = 1'b1; Addr = 24'h000012; Sel = 1'b0; Rd_DS = 1'b0; Wr_RW = 1'b1;
    tick(); tick();
    chk("rstack_pre_rdy", 32'(Rdy_Dtack), 32'd0);
    chk("rstack_pre_data", 32'(DataOut), 32'hA5C3);
    rst = 1'b1;
    tick();
    rst = 1'b0; release_bus();
    chk("rstack_rdy", 32'(Rdy_Dtack), 32'd1);
    chk("rstack_data", 32'(DataOut), 32'd0);
    tick();
    for (int i = 0; i < 256; i++) model[i] = '0;
    cpu_access(1'b1, 1'b0, 24'h000012, 16'h0, 1'b0, r);
    check_access("postrst_12", r, 16'h0000, 1'b0);
    cpu_access(1'b0, 1'b0, 24'h0000FF, 16'h0, 1'b0, r);
    check_access("postrst_ff", r, 16'h0000, 1'b0);
    lookup(8'd7, ld, lv, lp);
    chk("postrst_lkup7", 32'(ld), 32'd0);

    // Reset coinciding with a write's ACCESS cycle drops the write.
    BusMode = 1'b1; Addr = 24'h000020; DataIn = 16'h5555; Sel = 1'b0; Rd_DS = 1'b1; Wr_RW = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; release_bus();
    tick(); tick();
    cpu_access(1'b1, 1'b0, 24'h000020, 16'h0, 1'b0, r);
    check_access("rstacc_20", r, 16'h0000, 1'b0);

`ifdef CFG_PARITY_EN
    cpu_access(1'b1, 1'b1, 24'h000003, 16'h0001, 1'b1, r);
    lookup(8'd3, ld, lv, lp);
    chk("par_inj_perr", 32'(lp), 32'd1);
    chk("par_inj_data", 32'(ld), 32'h0001);
    cpu_access(1'b1, 1'b1, 24'h000003, 16'h0001, 1'b0, r);
    lookup(8'd3, ld, lv, lp);
    chk("par_ok_perr", 32'(lp), 32'd0);
    model[3] = 16'h0001;
`endif

    for (int n = 0; n < 80; n++) begin
      int          op;
      bit          mode, miss;
      logic [7:0]  idx;
      logic [15:0] upper, wd;
      op    = int'($urandom_range(0, 9));
      mode  = 1'($urandom_range(0, 1));
      idx   = 8'($urandom_range(0, 15));
      miss  = ($urandom_range(0, 7) == 0);
      upper = miss ? 16'($urandom_range(1, 65535)) : 16'h0000;
      wd    = 16'($urandom);
      if (op < 4) begin
        cpu_access(mode, 1'b1, {upper, idx}, wd, 1'b0, r);
        check_access($sformatf("rnd%0d_wr", n), r, 16'h0000, miss);
        if (!miss) model[idx] = wd;
      end else if (op < 8) begin
        cpu_access(mode, 1'b0, {upper, idx}, 16'h0, 1'b0, r);
        check_access($sformatf("rnd%0d_rd", n), r, miss ? 16'h0000 : model[idx], miss);
      end else begin
        lookup(idx, ld, lv, lp);
        chk($sformatf("rnd%0d_lkup_vld", n), 32'(lv), 32'd1);
        chk($sformatf("rnd%0d_lkup_data", n), 32'(ld), 32'(model[idx]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_cfg_slave.md
# cpu_cfg_slave

Bus-slave peripheral that terminates the testbench CPU interface (Peripheral side) and owns the per-VPI cell configuration table of the switch. It decodes CPU read/write cycles in either bus mode, stores `CellCfgType` entries in a flop-based table, and answers with the `Rdy_Dtack` handshake. A second, independent lookup port lets the switch core read the table every cycle.

## Interface
- `ENTRIES`, 256: table depth; index = `Addr[7:0]`.
- `BASE`, 16'h0000: value `Addr[23:8]` must match for a decoded access.
- `CFG_W`, 16: entry width; must equal `$bits(CellCfgType)`.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `BusMode` input 1: 1 = Intel style (Rd/Wr/Rdy), 0 = Motorola style (DS/RW/Dtack).
- `Addr` input 24: byte address of the access.
- `Sel` input 1: chip select, active low.
- `DataIn` input CFG_W (`CellCfgType`): write data.
- `DataOut` output CFG_W (`CellCfgType`): read data.
- `Rd_DS` input 1: Intel: read strobe, active low. Motorola: data strobe, active low.
- `Wr_RW` input 1: Intel: write strobe, active low. Motorola: 1 = read, 0 = write.
- `Rdy_Dtack` output 1: ready/acknowledge, active low.
- `lkup_en` input 1: core lookup request.
- `lkup_addr` input 8: lookup index.
- `lkup_data` output CFG_W: lookup result.
- `lkup_vld` output 1: `lkup_data` valid.
- `err_addr` output 1: one-cycle pulse when an access misses `BASE`.

## Operation
- Cycle start in IDLE requires `Sel`=0 and one of the following:
  - Intel: exactly one of `Rd_DS`/`Wr_RW` low. Both low at once is ignored and the slave stays in IDLE.
  - Motorola: `Rd_DS` low; direction comes from `Wr_RW`.
- FSM states:
  - IDLE -> ACCESS on a cycle start. Latches address, direction and `DataIn`.
  - ACCESS -> ACK. Performs the table write, or registers the read data.
  - ACK: stays here while the strobe (Intel: the active strobe; Motorola: `Rd_DS`) is low or `Sel` is low.
  - ACK -> RELEASE when both the strobe and `Sel` are high.
  - RELEASE -> IDLE unconditionally. This gives one dead cycle before the next access.
- Decode miss (`Addr[23:8]`≠`BASE`):
  - write is dropped; read returns 0.
  - handshake still completes.
  - `err_addr` pulses in the ACCESS cycle.
- Write commit happens at the end of ACCESS. Data comes from `DataIn` as latched at cycle start.
- Lookup port:
  - `lkup_en` in cycle N gives `lkup_data`/`lkup_vld` in cycle N+1.
  - `lkup_vld`=0 gives `lkup_data`=0.
- CPU write and lookup to the same index in the same cycle: lookup returns the old value (read-first). The new value is visible from the next lookup.

## Timing
- Reset values: `Rdy_Dtack`=1, `DataOut`=0, `lkup_vld`=0, `lkup_data`=0, `err_addr`=0, FSM=IDLE, all table entries = 0.
- Strobe sampled low at edge N:
  - ACCESS at N+1.
  - `Rdy_Dtack`=0 and `DataOut` valid from N+2.
  - Both held through ACK.
- Strobe high sampled at edge M: `Rdy_Dtack`=1 and `DataOut`=0 from M+1 (RELEASE). The earliest next cycle start is sampled at M+2.
- `DataOut`=0 whenever `Rdy_Dtack`=1. Write ACKs also drive 0.
- `rst` in any state: next cycle is IDLE with outputs at reset values. A write whose ACCESS cycle coincides with `rst` is not committed.
- Inputs are changed by the bench away from the `clk` edge (clocking-block driven). No internal synchronizers.

## Configuration
- `CFG_PARITY_EN` defined:
  - each entry stores an extra even-parity bit.
  - extra ports `perr_inj` (input 1) and `lkup_perr` (output 1, reset 0).
  - `perr_inj`=1 during a write's ACCESS cycle stores inverted parity.
  - `lkup_perr`=1 alongside `lkup_vld` when stored parity mismatches the data. The CPU read path is unaffected.
- `CFG_PARITY_EN` undefined: no parity storage and neither extra port exists.

## Test plan
- Intel write `Addr`=24'h000012, `DataIn`=16'hA5C3, then Intel read of the same address:
  - `Rdy_Dtack` low 2 cycles after the strobe.
  - read `DataOut`=16'hA5C3.
  - `Rdy_Dtack` high 1 cycle after strobe release.
- Motorola write index 8'hFF = 16'h1234, then Motorola read (`Wr_RW`=1) of the same index -> `DataOut`=16'h1234. Index 8'h00 still reads 0.
- Read of `Addr`=24'h010005 with `BASE`=0:
  - `err_addr` pulses once.
  - `DataOut`=0 with ack.
  - a following write to 24'h010005 leaves entry 5 unchanged.
- Write entry 7 = 16'h00F0 while `lkup_en`=1 and `lkup_addr`=7 in the commit cycle -> `lkup_data`=0. The next lookup returns 16'h00F0 with `lkup_vld`=1.
- Assert `rst` during ACK of a read:
  - next cycle `Rdy_Dtack`=1, `DataOut`=0.
  - all previously written entries read back 0.
- With `CFG_PARITY_EN`: write entry 3 = 16'h0001 with `perr_inj`=1, then look up index 3 -> `lkup_perr`=1. Rewrite with `perr_inj`=0 and look up again -> `lkup_perr`=0.
